player_health_ctrl: RTL



---
 rtl/game_pkg.sv | 26 ++
 rtl/frame_down_counter.sv | 43 ++++
 rtl/player_health_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// ============================================================================
// game_pkg
// Shared game-state types and default frame-count constants (used by the
// player health controller, enemy AI and HUD).
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package game_pkg;

  // Player health state machine encoding
  typedef enum logic [1:0] {
    ALIVE  = 2'd0,
    INVULN = 2'd1,
    DEAD   = 2'd2
  } hp_state_t;

  // Default frame-count constants shared across game blocks
  localparam int DEF_MAX_HP        = 3;
  localparam int DEF_INVULN_FRAMES = 90;
  localparam int DEF_BLINK_FRAMES  = 6;
  localparam int DEF_REGEN_FRAMES  = 600;

endpackage

`default_nettype wire

// File: rtl/frame_down_counter.sv
// ============================================================================
// frame_down_counter
// Loadable down-counter advanced by frame_tick. Flags zero and the final
// count (1) so the owner can act on the tick that expires the count.
// Priority: clear > load > tick. Saturates at zero.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module frame_down_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  output logic         zero,
  output logic         last
);

  logic [W-1:0] count;

  // Count register: clear, reload, or decrement on a frame tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (tick && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);
  assign last = (count == W'(1));

endmodule

`default_nettype wire

// File: rtl/player_health_ctrl.sv
// ============================================================================
// player_health_ctrl
// Player damage / health controller. Registers the collision flag, removes
// one HP per accepted hit, runs a frame-counted invulnerability window with
// sprite blinking, and declares game over at zero HP.
// Optional feature macro: PLAYER_REGEN_EN (regenerate 1 HP every
// REGEN_FRAMES frames spent in ALIVE without a hit).
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module player_health_ctrl
  import game_pkg::*;
#(
  parameter int MAX_HP        = DEF_MAX_HP,
  parameter int INVULN_FRAMES = DEF_INVULN_FRAMES,
  parameter int BLINK_FRAMES  = DEF_BLINK_FRAMES,
  parameter int REGEN_FRAMES  = DEF_REGEN_FRAMES
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       frame_tick,
  input  logic                       enemy_collide,
  input  logic                       restart,
  output logic [$clog2(MAX_HP+1)-1:0] hp,
  output logic                       hit_pulse,
  output logic                       invuln,
  output logic                       sprite_visible,
  output logic                       game_over
);

  localparam int HP_W    = $clog2(MAX_HP + 1);
  localparam int INV_W   = $clog2(INVULN_FRAMES + 1);
  localparam int BLINK_W = $clog2(BLINK_FRAMES + 1);

  // Reject illegal parameterisations at elaboration
  if (MAX_HP < 1 || INVULN_FRAMES < 1 || BLINK_FRAMES < 1 || REGEN_FRAMES < 1) begin : g_bad_params
    $error("player_health_ctrl: all frame/HP parameters must be at least 1");
  end

  hp_state_t state;
  logic      coll_q;

  logic hit_take;
  logic inv_tick;
  logic inv_zero, inv_last;
  logic blink_zero, blink_last;
  logic inv_done;
  logic blink_wrap;

  // Single sampling register on the (possibly glitchy) collision flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) coll_q <= 1'b0;
    else        coll_q <= enemy_collide;
  end

  // Counter control: a hit arms the window, ticks only count inside INVULN
  always_comb begin
    hit_take   = (state == ALIVE) && coll_q && !restart;
    inv_tick   = (state == INVULN) && frame_tick && !restart;
    // A zero count inside INVULN cannot occur normally; treat it as expiry
    // so the window can never get stuck.
    inv_done   = inv_tick && (inv_last || inv_zero);
    blink_wrap = inv_tick && (blink_last || blink_zero);
  end

  frame_down_counter #(.W(INV_W)) u_inv_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (restart),
    .load     (hit_take),
    .load_val (INV_W'(INVULN_FRAMES)),
    .tick     (inv_tick),
    .zero     (inv_zero),
    .last     (inv_last)
  );

  frame_down_counter #(.W(BLINK_W)) u_blink_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (restart),
    .load     (hit_take || blink_wrap),
    .load_val (BLINK_W'(BLINK_FRAMES)),
    .tick     (inv_tick),
    .zero     (blink_zero),
    .last     (blink_last)
  );

`ifdef PLAYER_REGEN_EN
  localparam int REGEN_W = $clog2(REGEN_FRAMES + 1);

  logic regen_active;
  logic regen_tick;
  logic regen_done;
  logic regen_zero, regen_last;

  // Regen runs only in ALIVE below full health with no hit pending; an idle
  // (zero) counter is loaded with REGEN_FRAMES-1 so the starting tick counts.
  always_comb begin
    regen_active = (state == ALIVE) && (hp < HP_W'(MAX_HP)) && !coll_q && !restart;
    regen_tick   = regen_active && frame_tick;
    regen_done   = regen_tick && (regen_last || (regen_zero && (REGEN_FRAMES == 1)));
  end

  frame_down_counter #(.W(REGEN_W)) u_regen_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (restart || hit_take || regen_done),
    .load     (regen_tick && regen_zero),
    .load_val (REGEN_W'(REGEN_FRAMES - 1)),
    .tick     (regen_tick),
    .zero     (regen_zero),
    .last     (regen_last)
  );
`endif

  // Health state machine with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ALIVE;
      hp             <= HP_W'(MAX_HP);
      hit_pulse      <= 1'b0;
      invuln         <= 1'b0;
      sprite_visible <= 1'b1;
      game_over      <= 1'b0;
    end else begin
      hit_pulse <= 1'b0;
      if (restart) begin
        state          <= ALIVE;
        hp             <= HP_W'(MAX_HP);
        invuln         <= 1'b0;
        sprite_visible <= 1'b1;
        game_over      <= 1'b0;
      end else begin
        case (state)
          ALIVE: begin
            if (coll_q) begin
              hit_pulse <= 1'b1;
              hp        <= hp - HP_W'(1);
              if (hp == HP_W'(1)) begin
                state          <= DEAD;
                game_over      <= 1'b1;
                sprite_visible <= 1'b1;
              end else begin
                state          <= INVULN;
                invuln         <= 1'b1;
                sprite_visible <= 1'b0;
              end
            end
`ifdef PLAYER_REGEN_EN
            else if (regen_done) begin
              hp <= hp + HP_W'(1);
            end
`endif
          end
          INVULN: begin
            if (inv_done) begin
              state          <= ALIVE;
              invuln         <= 1'b0;
              sprite_visible <= 1'b1;
            end else if (blink_wrap) begin
              sprite_visible <= ~sprite_visible;
            end
          end
          DEAD: begin
            game_over      <= 1'b1;
            sprite_visible <= 1'b1;
          end
          default: begin
            state          <= ALIVE;
            invuln         <= 1'b0;
            sprite_visible <= 1'b1;
            game_over      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire
